// File: rtl/trace_buffer.sv
// Commit-trace capture FIFO: records WB-stage commits while enabled, drains
// first-word-fall-through. Optional macro TRACE_FILTER_EN keeps only commits that write x1..x31.
module trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic                     in_have_inst,
    input  logic [31:0]              in_pc,
    input  logic                     in_ena,
    input  logic [4:0]               in_reg,
    input  logic [31:0]              in_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic                     out_ena,
    output logic [4:0]               out_reg,
    output logic [31:0]              out_value,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_cnt,
    output logic                     frozen,
    output logic [1:0]               state_dbg
);

    // Drain handshake: a record leaves on every rising edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0, out_* hold steady.

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [69:0]    mem [DEPTH];
    logic [69:0]    in_rec;
    logic [69:0]    out_rec;

    logic commit_ok;
    logic attempt;
    logic full;
    logic pop;
    logic push;
    logic overflow;

`ifdef TRACE_FILTER_EN
    assign commit_ok = in_have_inst & in_ena & (in_reg != 5'd0);
`else
    assign commit_ok = in_have_inst;
`endif

    assign attempt  = (state == ST_RUN) & cap_en & commit_ok;
    assign full     = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop      = out_valid & out_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push     = attempt & (~full | pop);
    assign overflow = attempt & full & ~pop;

    assign in_rec   = {in_pc, in_ena, in_reg, in_value};
    assign out_rec  = mem[rd_ptr];
    assign out_pc    = out_rec[69:38];
    assign out_ena   = out_rec[37];
    assign out_reg   = out_rec[36:32];
    assign out_value = out_rec[31:0];

    assign frozen    = (state == ST_FROZEN);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cap_en) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!cap_en) state_next = ST_IDLE;
                else if (overflow && (STOP_ON_FULL != 0)) state_next = ST_FROZEN;
            end
            ST_FROZEN: begin
                if (!cap_en && (count == '0)) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Storage is deliberately not reset; reset only discards via the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= in_rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if ((state == ST_IDLE) && (state_next == ST_RUN)) begin
            drop_cnt <= '0;
        end else if (overflow && (STOP_ON_FULL == 0) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: two DEPTH=4 instances (drop mode and stop-on-full mode)
// driven with the same inputs and compared each cycle against a queue-based model.
module tb_trace_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  rg;
        logic [31:0] val;
    } rec_t;

    localparam int TB_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        cap_en;
    logic        in_have_inst;
    logic [31:0] in_pc;
    logic        in_ena;
    logic [4:0]  in_reg;
    logic [31:0] in_value;
    logic        out_ready;

    logic        out_valid0, out_valid1;
    logic [31:0] out_pc0, out_pc1;
    logic        out_ena0, out_ena1;
    logic [4:0]  out_reg0, out_reg1;
    logic [31:0] out_value0, out_value1;
    logic [2:0]  count0, count1;
    logic [15:0] drop_cnt0, drop_cnt1;
    logic        frozen0, frozen1;
    logic [1:0]  state_dbg0, state_dbg1;

    int vectors;
    int miscompares;

    rec_t q0[$];
    rec_t q1[$];
    int   mode0, mode1;   // 0 idle, 1 run, 2 frozen
    int   drop0, drop1;

    trace_buffer #(.DEPTH(TB_DEPTH), .STOP_ON_FULL(0)) dut0 (
        .clk(clk), .rst(rst), .cap_en(cap_en), .in_have_inst(in_have_inst),
        .in_pc(in_pc), .in_ena(in_ena), .in_reg(in_reg), .in_value(in_value),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0),
        .out_ena(out_ena0), .out_reg(out_reg0), .out_value(out_value0),
        .count(count0), .drop_cnt(drop_cnt0), .frozen(frozen0), .state_dbg(state_dbg0)
    );

    trace_buffer #(.DEPTH(TB_DEPTH), .STOP_ON_FULL(1)) dut1 (
        .clk(clk), .rst(rst), .cap_en(cap_en), .in_have_inst(in_have_inst),
        .in_pc(in_pc), .in_ena(in_ena), .in_reg(in_reg), .in_value(in_value),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1),
        .out_ena(out_ena1), .out_reg(out_reg1), .out_value(out_value1),
        .count(count1), .drop_cnt(drop_cnt1), .frozen(frozen1), .state_dbg(state_dbg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit qualifies(input logic hv, input logic ena, input logic [4:0] rg);
`ifdef TRACE_FILTER_EN
        return hv && ena && (rg != 5'd0);
`else
        return hv;
`endif
    endfunction

    // Decide what one clock edge does to an abstract trace buffer.
    task automatic decide(input int sof, input int size, input int mode, input int drops,
                          output bit do_pop, output bit do_push,
                          output int nmode, output int ndrops);
        bit att, full, ovf;
        do_pop = (size != 0) && out_ready;
        att    = (mode == 1) && cap_en && qualifies(in_have_inst, in_ena, in_reg);
        full   = (size == TB_DEPTH);
        do_push = att && (!full || do_pop);
        ovf    = att && full && !do_pop;
        nmode  = mode;
        ndrops = drops;
        if (mode == 0) begin
            if (cap_en) begin
                nmode  = 1;
                ndrops = 0;
            end
        end else if (mode == 1) begin
            if (!cap_en) nmode = 0;
            else if (ovf && sof != 0) nmode = 2;
            if (ovf && sof == 0 && drops < 65535) ndrops = drops + 1;
        end else begin
            if (!cap_en && size == 0) nmode = 0;
        end
    endtask

    task automatic check_one(input string n, input int size, input rec_t head,
                             input int mode, input int drops,
                             input logic [2:0] cnt, input logic [15:0] dc,
                             input logic fz, input logic ov, input logic [1:0] st,
                             input logic [31:0] pc, input logic ena,
                             input logic [4:0] rg, input logic [31:0] val);
        chk({n, "_count"}, 32'(cnt), 32'(size));
        chk({n, "_drop_cnt"}, 32'(dc), 32'(drops));
        chk({n, "_frozen"}, 32'(fz), 32'(mode == 2));
        chk({n, "_out_valid"}, 32'(ov), 32'(size != 0));
        chk({n, "_state"}, 32'(st), 32'(mode));
        if (size != 0) begin
            chk({n, "_out_pc"}, pc, head.pc);
            chk({n, "_out_ena"}, 32'(ena), 32'(head.ena));
            chk({n, "_out_reg"}, 32'(rg), 32'(head.rg));
            chk({n, "_out_value"}, val, head.val);
        end
    endtask

    task automatic check_all();
        rec_t h0, h1;
        h0 = (q0.size() != 0) ? q0[0] : '0;
        h1 = (q1.size() != 0) ? q1[0] : '0;
        check_one("d0", q0.size(), h0, mode0, drop0, count0, drop_cnt0, frozen0,
                  out_valid0, state_dbg0, out_pc0, out_ena0, out_reg0, out_value0);
        check_one("d1", q1.size(), h1, mode1, drop1, count1, drop_cnt1, frozen1,
                  out_valid1, state_dbg1, out_pc1, out_ena1, out_reg1, out_value1);
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic r, input logic ce, input logic hv, input logic [31:0] pc,
                        input logic ena, input logic [4:0] rg, input logic [31:0] val,
                        input logic rdy);
        bit p, u;
        int nm, nd;
        rec_t rec;
        rst = r; cap_en = ce; in_have_inst = hv; in_pc = pc;
        in_ena = ena; in_reg = rg; in_value = val; out_ready = rdy;
        rec = '{pc: pc, ena: ena, rg: rg, val: val};
        @(posedge clk);
        decide(0, q0.size(), mode0, drop0, p, u, nm, nd);
        if (r) begin
            q0.delete(); mode0 = 0; drop0 = 0;
        end else begin
            if (p) void'(q0.pop_front());
            if (u) q0.push_back(rec);
            mode0 = nm; drop0 = nd;
        end
        decide(1, q1.size(), mode1, drop1, p, u, nm, nd);
        if (r) begin
            q1.delete(); mode1 = 0; drop1 = 0;
        end else begin
            if (p) void'(q1.pop_front());
            if (u) q1.push_back(rec);
            mode1 = nm; drop1 = nd;
        end
        #1;
        check_all();
    endtask

    task automatic commit(input logic [31:0] pc, input logic rdy);
        step(1'b0, 1'b1, 1'b1, pc, 1'b1, 5'd1, $urandom, rdy);
    endtask

    task automatic idle_cycle(input logic ce, input logic rdy);
        step(1'b0, ce, 1'b0, $urandom, 1'b0, 5'd0, $urandom, rdy);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mode0 = 0; mode1 = 0; drop0 = 0; drop1 = 0;
        rst = 1'b1; cap_en = 1'b0; in_have_inst = 1'b0; in_pc = '0;
        in_ena = 1'b0; in_reg = '0; in_value = '0; out_ready = 1'b0;

        // Reset
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 5'd1, 32'h0, 1'b1);
        chk("reset_count", 32'(count0), 32'd0);
        chk("reset_valid", 32'(out_valid0), 32'd0);

        // Three commits held, then drained in order
        idle_cycle(1'b1, 1'b0);
        commit(32'h0, 1'b0);
        commit(32'h4, 1'b0);
        commit(32'h8, 1'b0);
        chk("s1_count", 32'(count0), 32'd3);
        chk("s1_head", out_pc0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("s1_drain_pc", out_pc0, 32'(4 * i));
            idle_cycle(1'b1, 1'b1);
        end
        chk("s1_empty", 32'(out_valid0), 32'd0);

        // Six commits into a 4-deep buffer: drop mode vs stop-on-full
        for (int i = 0; i < 6; i++) commit(32'h100 + 32'(4 * i), 1'b0);
        chk("s2_count0", 32'(count0), 32'd4);
        chk("s2_drop0", 32'(drop_cnt0), 32'd2);
        chk("s2_frozen1", 32'(frozen1), 32'd1);
        chk("s2_drop1", 32'(drop_cnt1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("s2_drain_pc0", out_pc0, 32'h100 + 32'(4 * i));
            chk("s2_drain_pc1", out_pc1, 32'h100 + 32'(4 * i));
            idle_cycle(1'b0, 1'b1);
        end
        idle_cycle(1'b0, 1'b1);
        chk("s2_state1", 32'(state_dbg1), 32'd0);
        chk("s2_unfrozen1", 32'(frozen1), 32'd0);

        // Full buffer with simultaneous pop and commit
        idle_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) commit(32'h30 + 32'(4 * i), 1'b0);
        commit(32'h40, 1'b1);
        chk("s3_count", 32'(count0), 32'd4);
        chk("s3_drop", 32'(drop_cnt0), 32'd0);
        chk("s3_frozen1", 32'(frozen1), 32'd0);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0, 1'b1);
        chk("s3_last_pc", out_pc0, 32'h40);
        idle_cycle(1'b0, 1'b1);
        chk("s3_empty", 32'(out_valid0), 32'd0);

        // Commit filtering
        idle_cycle(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 5'd0, 32'h1111, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h204, 1'b0, 5'd5, 32'h2222, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h208, 1'b1, 5'd5, 32'h1234, 1'b0);
`ifdef TRACE_FILTER_EN
        chk("s4_count", 32'(count0), 32'd1);
        chk("s4_reg", 32'(out_reg0), 32'd5);
        chk("s4_value", out_value0, 32'h1234);
`else
        chk("s4_count", 32'(count0), 32'd3);
        chk("s4_reg", 32'(out_reg0), 32'd0);
        chk("s4_value", out_value0, 32'h1111);
`endif
        for (int i = 0; i < 3; i++) idle_cycle(1'b0, 1'b1);

        // Reset in the middle of operation
        idle_cycle(1'b1, 1'b0);
        for (int i = 0; i < 11; i++) commit(32'h300 + 32'(4 * i), 1'b0);
        idle_cycle(1'b1, 1'b1);
        chk("s5_pre_count", 32'(count0), 32'd3);
        chk("s5_pre_drop", 32'(drop_cnt0), 32'd7);
        step(1'b1, 1'b1, 1'b1, 32'h3ff, 1'b1, 5'd3, 32'h0, 1'b1);
        chk("s5_count", 32'(count0), 32'd0);
        chk("s5_drop", 32'(drop_cnt0), 32'd0);
        chk("s5_valid", 32'(out_valid0), 32'd0);
        chk("s5_state", 32'(state_dbg0), 32'd0);
        chk("s5_state1", 32'(state_dbg1), 32'd0);
        idle_cycle(1'b1, 1'b0);
        chk("s5_run", 32'(state_dbg0), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) != 0),
                 $urandom,
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)),
                 $urandom,
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, at least 2.
REQ-002 SHALL have parameter STOP_ON_FULL, default 0; 1 freezes capture on first overflow, 0 drops and counts.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cap_en  input  1  capture enable from debug controller.
REQ-006 SHALL have ports in_have_inst / in_pc / in_ena / in_reg / in_value  input  1/32/1/5/32  WB-stage commit record (have-inst flag, PC, reg write enable, reg number, write value).
REQ-007 SHALL have ports out_valid  output  1  and out_ready  input  1; out_valid/out_ready form the drain handshake.
REQ-008 SHALL have ports out_pc / out_ena / out_reg / out_value  output  32/1/5/32  head-entry record.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-010 SHALL have port drop_cnt  output  16  number of discarded commits.
REQ-011 SHALL have port frozen  output  1  high while state is FROZEN.

Function
REQ-012 SHALL implement states IDLE, RUN, FROZEN, held in a state register.
REQ-013 SHALL go IDLE->RUN when cap_en=1, and RUN->IDLE when cap_en=0.
REQ-014 SHALL go RUN->FROZEN, with STOP_ON_FULL=1 only, on a capture attempt while full with no pop that cycle.
REQ-015 SHALL go FROZEN->IDLE only when cap_en=0 and count=0; otherwise stay FROZEN.
REQ-016 SHALL define a capture attempt as state=RUN, cap_en=1 and in_have_inst=1; in IDLE and FROZEN in_* is ignored.
REQ-017 SHALL define a pop as out_valid & out_ready.
REQ-018 SHALL write a capture attempt at the tail when not full, or when full with a pop in the same cycle (slot freed).
REQ-019 SHALL hold out_* on the head entry, first-word-fall-through: a record captured at edge N is on out_* with out_valid=1 after edge N, when the FIFO was empty.
REQ-020 SHALL hold out_valid = (count != 0), and keep out_* stable while out_valid=1 and out_ready=0.
REQ-021 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-022 SHALL keep count within 0..DEPTH; pointers wrap modulo DEPTH.
REQ-023 SHALL ignore out_ready while count=0; there is no underflow.
REQ-024 SHALL, with STOP_ON_FULL=0, drop a capture attempt while full with no pop and increment drop_cnt, saturating at 16'hFFFF.
REQ-025 SHALL, with STOP_ON_FULL=1, not increment drop_cnt on the freezing attempt; the lost record is signalled by frozen=1.
REQ-026 SHALL keep draining (pops) in every state, including FROZEN.
REQ-027 SHALL clear drop_cnt on the edge where the state goes IDLE->RUN.

Reset
REQ-028 SHALL on rst=1 at a clock edge set state=IDLE, read and write pointers=0, count=0, drop_cnt=0, frozen=0, out_valid=0.
REQ-029 SHALL on rst=1 discard stored entries without clearing storage RAM; out_pc/out_ena/out_reg/out_value are don't-care while out_valid=0.
REQ-030 SHALL let rst override simultaneous capture and pop in that cycle.
REQ-031 SHALL after rst deassertion act on cap_en from the first edge.

Configuration
REQ-032 SHALL use macro TRACE_FILTER_EN to control commit filtering.
REQ-033 SHALL, with TRACE_FILTER_EN defined, count a capture attempt only if additionally in_ena=1 and in_reg!=0 (no x0/non-writing commits).
REQ-034 SHALL, with TRACE_FILTER_EN undefined, capture every commit with in_have_inst=1 regardless of in_ena/in_reg.
REQ-035 SHALL make filtered-out commits neither push nor count as drops.

Verification
REQ-036 Bench SHALL cover: DEPTH=4, cap_en=1, out_ready=0, commit PCs 0x0,0x4,0x8 -> count=3, out_pc=0x0; then out_ready=1 for 3 cycles -> out_pc 0x0,0x4,0x8, then out_valid=0.
REQ-037 Bench SHALL cover: DEPTH=4, STOP_ON_FULL=0, out_ready=0, 6 commits -> count=4, drop_cnt=2, drained PCs are the first four.
REQ-038 Bench SHALL cover: DEPTH=4, STOP_ON_FULL=1, 5 commits -> frozen=1 after the 5th; further commits ignored; drain 4 with cap_en=0 -> state IDLE, frozen=0.
REQ-039 Bench SHALL cover: full FIFO with out_ready=1 and a commit (PC 0x40) in the same cycle -> count stays 4, drop_cnt unchanged, 0x40 drained last.
REQ-040 Bench SHALL cover: TRACE_FILTER_EN defined, commits (ena=1,reg=0),(ena=0,reg=5),(ena=1,reg=5,value=0x1234) -> count=1, out_reg=5, out_value=0x1234.
REQ-041 Bench SHALL cover: rst=1 mid-operation with count=3 and drop_cnt=7 -> next cycle count=0, drop_cnt=0, out_valid=0, state IDLE.
